branch_predict_unit: RTL and testbench

//  Dynamic branch predictor for the 5-stage pipeline: 2-bit-counter BHT plus tagged BTB, looked up in IF.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/branch_predict_unit_if.sv | 39 +++
 rtl/bp_table.sv | 77 +++++++
 rtl/branch_predict_unit.sv | 131 +++++++++++++
 tb/tb_branch_predict_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings and helpers for the branch predictor
// Purpose: 2-bit saturating counter states and increment/decrement helpers.
// Ports: none (package).
package bp_pkg;

  localparam int CTR_W = 2;

  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Counter value given to a freshly allocated entry.
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_WT;

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup / resolution / stats bundle
// Purpose: groups the IF-stage lookup, stage-4 resolution and statistics signals.
// Ports: slave = predictor (inputs fetch_pc/res_*, outputs pred_*/mispredict/redirect_pc/stat_*),
//        master = pipeline side (mirror image).
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic              res_is_br;
  logic              res_is_jmp;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport slave (
    input  fetch_pc, res_valid, res_pc, res_is_br, res_is_jmp, res_taken,
           res_target, res_pred_taken, res_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispred
  );

  modport master (
    output fetch_pc, res_valid, res_pc, res_is_br, res_is_jmp, res_taken,
           res_target, res_pred_taken, res_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispred
  );
endinterface

// File: rtl/bp_table.sv
// rtl/bp_table.sv - direct-mapped BHT/BTB entry storage
// Purpose: 2^IDX_W entries of {valid, tag, target, jmp, ctr}; two async read ports
//          (lookup, update) and one sync write port at the update index.
// Ports: clk, rst (async, active-high; clears valid, ctr to CTR_INIT),
//        lk_idx -> lk_*, up_idx -> up_*, wr_en + wr_* written at up_idx.
module bp_table
  import bp_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              IDX_W    = 6,
  parameter int              TAG_W    = 8,
  parameter logic [CTR_W-1:0] CTR_INIT = CTR_WNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_valid,
  output logic [TAG_W-1:0]  lk_tag,
  output logic [ADDR_W-1:0] lk_target,
  output logic              lk_jmp,
  output logic [CTR_W-1:0]  lk_ctr,
  input  logic [IDX_W-1:0]  up_idx,
  output logic              up_valid,
  output logic [TAG_W-1:0]  up_tag,
  output logic [ADDR_W-1:0] up_target,
  output logic              up_jmp,
  output logic [CTR_W-1:0]  up_ctr,
  input  logic              wr_en,
  input  logic              wr_valid,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_target,
  input  logic              wr_jmp,
  input  logic [CTR_W-1:0]  wr_ctr
);
  localparam int DEPTH = 1 << IDX_W;

  logic              valid_q  [DEPTH];
  logic [CTR_W-1:0]  ctr_q    [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic              jmp_q    [DEPTH];

  // Reads see the stored state only, so a same-cycle write is invisible until next cycle.
  assign lk_valid  = valid_q[lk_idx];
  assign lk_tag    = tag_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign lk_jmp    = jmp_q[lk_idx];
  assign lk_ctr    = ctr_q[lk_idx];

  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_jmp    = jmp_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (wr_en) begin
      valid_q[up_idx] <= wr_valid;
      ctr_q[up_idx]   <= wr_ctr;
    end
  end

  // Payload fields are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[up_idx]    <= wr_tag;
      target_q[up_idx] <= wr_target;
      jmp_q[up_idx]    <= wr_jmp;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit BHT + tagged BTB branch predictor top
// Purpose: zero-latency IF lookup, stage-4 mispredict detection, table training, stats.
// Ports: clk, reset (async, active-high), bus (branch_predict_unit_if.slave):
//        fetch_pc -> pred_hit/pred_taken/pred_target; res_* -> mispredict/redirect_pc;
//        stat_branches/stat_mispred saturating counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               IDX_W    = 6,
  parameter int               TAG_W    = 8,
  parameter logic [CTR_W-1:0] CTR_INIT = CTR_WNT,
  parameter int               STAT_W   = 16
) (
  input logic                   clk,
  input logic                   reset,
  branch_predict_unit_if.slave  bus
);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [IDX_W-1:0]  f_idx, r_idx;
  logic [TAG_W-1:0]  f_tag, r_tag;

  logic              lk_valid, up_valid;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic [ADDR_W-1:0] lk_target, up_target;
  logic              lk_jmp, up_jmp;
  logic [CTR_W-1:0]  lk_ctr, up_ctr;

  logic              wr_en, wr_valid, wr_jmp;
  logic [TAG_W-1:0]  wr_tag;
  logic [ADDR_W-1:0] wr_target;
  logic [CTR_W-1:0]  wr_ctr;

  logic              r_hit, is_bj, mis;
  logic [STAT_W-1:0] stat_br_q, stat_mis_q;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign r_idx = bus.res_pc[IDX_W+1:2];
  assign r_tag = bus.res_pc[IDX_W+TAG_W+1:IDX_W+2];

  bp_table #(
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .CTR_INIT(CTR_INIT)
  ) u_table (
    .clk      (clk),
    .rst      (reset),
    .lk_idx   (f_idx),
    .lk_valid (lk_valid),
    .lk_tag   (lk_tag),
    .lk_target(lk_target),
    .lk_jmp   (lk_jmp),
    .lk_ctr   (lk_ctr),
    .up_idx   (r_idx),
    .up_valid (up_valid),
    .up_tag   (up_tag),
    .up_target(up_target),
    .up_jmp   (up_jmp),
    .up_ctr   (up_ctr),
    .wr_en    (wr_en),
    .wr_valid (wr_valid),
    .wr_tag   (wr_tag),
    .wr_target(wr_target),
    .wr_jmp   (wr_jmp),
    .wr_ctr   (wr_ctr)
  );

  // Lookup: jumps always redirect on a hit; branches follow the counter MSB.
  assign bus.pred_hit    = lk_valid && (lk_tag == f_tag);
  assign bus.pred_taken  = bus.pred_hit && (lk_jmp || lk_ctr[1]);
  assign bus.pred_target = bus.pred_taken ? lk_target : bus.fetch_pc + PC_STEP;

  // A taken outcome that went to a different target than predicted is also a mispredict.
  // Gated by reset so a resolution in flight during reset cannot flush the pipeline.
  assign mis = !reset && bus.res_valid &&
               ((bus.res_taken != bus.res_pred_taken) ||
                (bus.res_taken && (bus.res_target != bus.res_pred_target)));
  assign bus.mispredict  = mis;
  assign bus.redirect_pc = bus.res_taken ? bus.res_target : bus.res_pc + PC_STEP;

  assign is_bj = bus.res_is_br || bus.res_is_jmp;
  assign r_hit = up_valid && (up_tag == r_tag);

  // Training: write-back defaults to the current entry so only changed fields move.
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = up_valid;
    wr_tag    = up_tag;
    wr_target = up_target;
    wr_jmp    = up_jmp;
    wr_ctr    = up_ctr;
    if (bus.res_valid) begin
      if (is_bj && r_hit) begin
        wr_en  = 1'b1;
        wr_ctr = bus.res_taken ? ctr_inc(up_ctr) : ctr_dec(up_ctr);
        if (bus.res_taken) wr_target = bus.res_target;
      end else if (is_bj && bus.res_taken) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = r_tag;
        wr_target = bus.res_target;
        wr_jmp    = bus.res_is_jmp;
        wr_ctr    = CTR_ALLOC;
      end else if (!is_bj && r_hit) begin
        // A non-branch matched an entry: stale alias, drop it.
        wr_en    = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (bus.res_valid && is_bj && (stat_br_q != STAT_MAX))
        stat_br_q <= stat_br_q + STAT_W'(1);
      if (mis && (stat_mis_q != STAT_MAX))
        stat_mis_q <= stat_mis_q + STAT_W'(1);
    end
  end

  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispred  = stat_mis_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.ADDR_W(32), .STAT_W(16)) bus();

  branch_predict_unit #(
    .ADDR_W(32), .IDX_W(6), .TAG_W(8), .CTR_INIT(2'b01), .STAT_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference tables: 64 entries, counters held as plain integers 0..3.
  int          mv  [64];
  int          mt  [64];
  int          mj  [64];
  int          mc  [64];
  logic [31:0] mtg [64];
  int          m_br;
  int          m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0; mt[i] = 0; mj[i] = 0; mc[i] = 1; mtg[i] = '0;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic hit,
                               output logic tk, output logic [31:0] tgt);
    int i;
    i   = idx_of(pc);
    hit = (mv[i] != 0) && (mt[i] == tag_of(pc));
    tk  = hit && ((mj[i] != 0) || (mc[i] >= 2));
    tgt = tk ? mtg[i] : pc + 32'd4;
  endtask

  function automatic logic model_mis();
    if (reset || !bus.res_valid) return 1'b0;
    if (bus.res_taken != bus.res_pred_taken) return 1'b1;
    return bus.res_taken && (bus.res_target != bus.res_pred_target);
  endfunction

  task automatic model_update();
    int  i;
    bit  hit, bj;
    if (reset) begin
      model_reset();
      return;
    end
    if (!bus.res_valid) return;
    i   = idx_of(bus.res_pc);
    hit = (mv[i] != 0) && (mt[i] == tag_of(bus.res_pc));
    bj  = bus.res_is_br || bus.res_is_jmp;
    if (bj && m_br < 65535) m_br++;
    if (model_mis() && m_mis < 65535) m_mis++;
    if (bj && hit) begin
      if (bus.res_taken) begin
        mc[i]  = (mc[i] == 3) ? 3 : mc[i] + 1;
        mtg[i] = bus.res_target;
      end else begin
        mc[i]  = (mc[i] == 0) ? 0 : mc[i] - 1;
      end
    end else if (bj && bus.res_taken) begin
      mv[i] = 1; mt[i] = tag_of(bus.res_pc); mtg[i] = bus.res_target;
      mj[i] = bus.res_is_jmp ? 1 : 0; mc[i] = 2;
    end else if (!bj && hit) begin
      mv[i] = 0;
    end
  endtask

  task automatic check_model();
    logic        hit, tk;
    logic [31:0] tgt;
    model_predict(bus.fetch_pc, hit, tk, tgt);
    check("pred_hit", 32'(bus.pred_hit), 32'(hit));
    check("pred_taken", 32'(bus.pred_taken), 32'(tk));
    check("pred_target", bus.pred_target, tgt);
    check("mispredict", 32'(bus.mispredict), 32'(model_mis()));
    check("redirect_pc", bus.redirect_pc,
          bus.res_taken ? bus.res_target : bus.res_pc + 32'd4);
    check("stat_branches", 32'(bus.stat_branches), 32'(m_br));
    check("stat_mispred", 32'(bus.stat_mispred), 32'(m_mis));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_res(input logic v, input logic br, input logic jmp, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    bus.res_valid       = v;
    bus.res_is_br       = br;
    bus.res_is_jmp      = jmp;
    bus.res_pc          = pc;
    bus.res_taken       = tk;
    bus.res_target      = tgt;
    bus.res_pred_taken  = ptk;
    bus.res_pred_target = ptgt;
  endtask

  task automatic idle_res();
    set_res(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | (32'($urandom_range(1, 3)) << 16);
    return pc;
  endfunction

  initial begin
    logic        hit, tk;
    logic [31:0] tgt, pc;
    int          kind;

    reset = 1'b1;
    idle_res();
    bus.fetch_pc = 32'h40;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: cold after reset
    #1;
    check("t1_hit", 32'(bus.pred_hit), 32'd0);
    check("t1_taken", 32'(bus.pred_taken), 32'd0);
    check("t1_target", bus.pred_target, 32'h44);
    check("t1_stats", 32'(bus.stat_branches) | 32'(bus.stat_mispred), 32'd0);
    step();

    // 2: first taken resolution allocates
    set_res(1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
    #1;
    check("t2_mis", 32'(bus.mispredict), 32'd1);
    check("t2_redirect", bus.redirect_pc, 32'h80);
    step();
    idle_res();
    #1;
    check("t2_hit", 32'(bus.pred_hit), 32'd1);
    check("t2_taken", 32'(bus.pred_taken), 32'd1);
    check("t2_target", bus.pred_target, 32'h80);
    step();

    // 3: train down to strongly not-taken and saturate
    set_res(1, 1, 0, 32'h40, 0, 32'h80, 1, 32'h80);
    #1;
    check("t3_mis1", 32'(bus.mispredict), 32'd1);
    check("t3_redirect", bus.redirect_pc, 32'h44);
    step();
    idle_res();
    #1;
    check("t3_taken_wnt", 32'(bus.pred_taken), 32'd0);
    step();
    set_res(1, 1, 0, 32'h40, 0, 32'h80, 0, 32'h44);
    #1;
    check("t3_mis2", 32'(bus.mispredict), 32'd0);
    step();
    step();
    idle_res();
    #1;
    check("t3_sat_hit", 32'(bus.pred_hit), 32'd1);
    check("t3_sat_taken", 32'(bus.pred_taken), 32'd0);
    check("t3_branches", 32'(bus.stat_branches), 32'd4);
    check("t3_mispred", 32'(bus.stat_mispred), 32'd2);
    step();

    // 4: jump entry ignores counter; alias cleanup
    bus.fetch_pc = 32'h100;
    set_res(1, 0, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    step();
    set_res(1, 0, 1, 32'h100, 0, 32'h200, 1, 32'h200);
    step();
    step();
    idle_res();
    #1;
    check("t4_jmp_taken", 32'(bus.pred_taken), 32'd1);
    check("t4_jmp_target", bus.pred_target, 32'h200);
    step();
    set_res(1, 0, 0, 32'h100, 0, 32'h0, 1, 32'h200);
    #1;
    check("t4_alias_mis", 32'(bus.mispredict), 32'd1);
    check("t4_alias_redirect", bus.redirect_pc, 32'h104);
    step();
    idle_res();
    #1;
    check("t4_alias_cleared", 32'(bus.pred_hit), 32'd0);
    check("t4_alias_target", bus.pred_target, 32'h104);
    step();

    // 5: same-cycle update and lookup at index 5
    bus.fetch_pc = 32'h14;
    set_res(1, 1, 0, 32'h14, 1, 32'h300, 0, 32'h18);
    #1;
    check("t5_old_hit", 32'(bus.pred_hit), 32'd0);
    check("t5_old_target", bus.pred_target, 32'h18);
    step();
    idle_res();
    #1;
    check("t5_new_hit", 32'(bus.pred_hit), 32'd1);
    check("t5_new_target", bus.pred_target, 32'h300);
    step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      pc   = rand_pc();
      kind = $urandom_range(0, 9);
      bus.res_valid  = ($urandom_range(0, 3) != 0);
      bus.res_pc     = pc;
      bus.res_is_br  = (kind < 6);
      bus.res_is_jmp = (kind >= 6 && kind < 9);
      if (kind < 6)      bus.res_taken = $urandom_range(0, 1) != 0;
      else if (kind < 9) bus.res_taken = $urandom_range(0, 9) != 0;
      else               bus.res_taken = 1'b0;
      bus.res_target = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      model_predict(pc, hit, tk, tgt);
      if ($urandom_range(0, 3) != 0) begin
        bus.res_pred_taken  = tk;
        bus.res_pred_target = tgt;
      end else begin
        bus.res_pred_taken  = $urandom_range(0, 1) != 0;
        bus.res_pred_target = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      end
      bus.fetch_pc = ($urandom_range(0, 2) == 0) ? pc : rand_pc();
      step();
    end

    // 6: reset asserted with a taken resolution in flight
    set_res(1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44);
    bus.fetch_pc = 32'h40;
    reset = 1'b1;
    #1;
    check("t6_mis_in_reset", 32'(bus.mispredict), 32'd0);
    check("t6_branches", 32'(bus.stat_branches), 32'd0);
    check("t6_mispred", 32'(bus.stat_mispred), 32'd0);
    model_reset();
    step();
    reset = 1'b0;
    idle_res();
    #1;
    check("t6_cold_hit", 32'(bus.pred_hit), 32'd0);
    check("t6_cold_target", bus.pred_target, 32'h44);
    step();

    // Mispredict counter saturation (non-branch alias pattern, cold tables)
    set_res(1, 0, 0, 32'h1000, 0, 32'h0, 1, 32'h2000);
    repeat (65536 + 3) begin
      @(posedge clk);
      model_update();
    end
    @(negedge clk);
    idle_res();
    #1;
    check("t6_sat_mispred", 32'(bus.stat_mispred), 32'hffff);
    check("t6_sat_model", 32'(bus.stat_mispred), 32'(m_mis));
    check("t6_sat_branches", 32'(bus.stat_branches), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
